multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core.
- Sequences the shared ALU, memory, register file and PC across Fetch, Decode, Execute, Memory and Writeback steps.
- Emits ALU_op, which feeds the ALU decoder that produces ALU_control.
- Adds a memory-ready handshake, a per-instruction retire pulse and an illegal-opcode flag.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- IR_write  out  1  instruction register load
- reg_dst  out  1  write register select: 1=rd, 0=rt
- mem_to_reg  out  1  write-back data select: 1=Data, 0=ALUOut
- reg_write  out  1  register file write enable
- ALU_src_A  out  1  ALU A select: 0=PC, 1=A
- ALU_src_B  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- ALU_op  out  2  to ALU decoder: 00=add, 01=sub, 10=funct
- PC_src  out  2  next PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- PC_en  out  1  PC load = PC_write | (branch & zero)
- state  out  4  current state, for debug
- instr_done  out  1  one-cycle retire pulse
- illegal_op  out  1  unsupported opcode seen in Decode

Behaviour:
- Single always block on posedge clk / negedge rst_n holds a 4-bit state register.
- rst_n=0: state=FETCH(0) immediately, asynchronously; effective mid-instruction with no completion.
- Outputs are a combinational function of state (plus mem_ready, opcode, zero where stated). Any output not listed for a state is 0.
- At reset the outputs are the FETCH values with mem_ready gating applied.
- States and asserted outputs:
  - 0 FETCH: ALU_src_B=01, IR_write=mem_ready, PC_write=mem_ready. Stay until mem_ready; then go to DECODE.
  - 1 DECODE: ALU_src_B=11. Next state by opcode: LW/SW→MEMADR, RTYPE→EXECUTE, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP. Any other opcode: illegal_op=1 this cycle, next state FETCH.
  - 2 MEMADR: ALU_src_A=1, ALU_src_B=10. Next MEMREAD if LW, else MEMWRITE.
  - 3 MEMREAD: IorD=1. Stay until mem_ready; then go to MEMWB.
  - 4 MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next FETCH.
  - 5 MEMWRITE: IorD=1, mem_write=1, held while waiting. When mem_ready: instr_done=1, next FETCH.
  - 6 EXECUTE: ALU_src_A=1, ALU_op=10. Next ALUWB.
  - 7 ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next FETCH.
  - 8 BRANCH: ALU_src_A=1, ALU_op=01, PC_src=01, branch=1, instr_done=1. Next FETCH.
  - 9 ADDIEX: ALU_src_A=1, ALU_src_B=10. Next ADDIWB.
  - 10 ADDIWB: reg_write=1, instr_done=1. Next FETCH.
  - 11 JUMP: PC_src=10, PC_write=1, instr_done=1. Next FETCH.
- branch and PC_write are internal signals that form PC_en only.
- States 12–15 are unreachable. If entered, all outputs are 0 and next state is FETCH.
- opcode is sampled in DECODE and MEMADR only; the IR is stable there because IR_write=0.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Exactly one instr_done pulse per legal instruction; none for illegal opcodes.

Test Plan:
- Reset and fetch: rst_n low, then high; mem_ready=1, opcode=000000 → state 0,1,6,7,0. IR_write=PC_en=1 in cycle 0. ALU_op=10 in state 6. reg_write=reg_dst=1 and instr_done=1 in state 7.
- lw with stall: opcode=100011, mem_ready=0 for 2 cycles in MEMREAD → state 0,1,2,3,3,3,4,0. IorD=1 through all state-3 cycles. mem_to_reg=reg_write=1 in state 4. 7 cycles total.
- beq: opcode=000100 with zero=1 → PC_en=1, PC_src=01, ALU_op=01 in state 8. Repeat with zero=0 → PC_en=0. instr_done=1 in both cases.
- sw and j: opcode=101011 → state 0,1,2,5,0 with mem_write=1 in state 5. opcode=000010 → state 0,1,11,0 with PC_src=10, PC_en=1.
- Illegal and fetch stall: opcode=111111 → illegal_op=1 in DECODE, next state 0, no instr_done. mem_ready=0 in FETCH → IR_write=PC_en=0 and state held at 0.
- Mid-op reset: assert rst_n=0 while in state 5 → state=0 and mem_write=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       mem_write;
  logic       IR_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       ALU_src_A;
  logic [1:0] ALU_src_B;
  logic [1:0] ALU_op;
  logic [1:0] PC_src;
  logic       PC_en;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  modport master (
    input  opcode, zero, mem_ready,
    output IorD, mem_write, IR_write, reg_dst, mem_to_reg, reg_write, ALU_src_A,
           ALU_src_B, ALU_op, PC_src, PC_en, state, instr_done, illegal_op
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  IorD, mem_write, IR_write, reg_dst, mem_to_reg, reg_write, ALU_src_A,
           ALU_src_B, ALU_op, PC_src, PC_en, state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle MIPS core with memory-ready stalls
module multicycle_controller #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  state_t state_q, state_d;
  logic pc_write, branch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d        = FETCH;
    pc_write       = 1'b0;
    branch         = 1'b0;
    bus.IorD       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.IR_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.ALU_src_A  = 1'b0;
    bus.ALU_src_B  = 2'b00;
    bus.ALU_op     = 2'b00;
    bus.PC_src     = 2'b00;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    case (state_q)
      FETCH: begin
        bus.ALU_src_B = 2'b01;
        bus.IR_write  = bus.mem_ready;
        pc_write      = bus.mem_ready;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALU_src_B = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      bus.illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.ALU_src_A = 1'b1;
        bus.ALU_src_B = 2'b10;
        state_d       = bus.opcode == OP_LW ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.IorD = 1'b1;
        state_d  = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEMWRITE: begin
        bus.IorD       = 1'b1;
        bus.mem_write  = 1'b1;
        bus.instr_done = bus.mem_ready;
        state_d        = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        bus.ALU_src_A = 1'b1;
        bus.ALU_op    = 2'b10;
        state_d       = ALUWB;
      end
      ALUWB: begin
        bus.reg_dst    = 1'b1;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.ALU_src_A  = 1'b1;
        bus.ALU_op     = 2'b01;
        bus.PC_src     = 2'b01;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
      end
      ADDIEX: begin
        bus.ALU_src_A = 1'b1;
        bus.ALU_src_B = 2'b10;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      JUMP: begin
        bus.PC_src     = 2'b10;
        pc_write       = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end
  assign bus.PC_en = pc_write | (branch & bus.zero);
  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction stream scored cycle-by-cycle against a path-level model
module tb_multicycle_controller;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  logic clk, rst_n;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int legal_n = 0, illegal_n = 0, done_cnt = 0, ill_cnt = 0;
  logic [19:0] q[$];
  logic [19:0] act;
  assign act = {bus.state, bus.IorD, bus.mem_write, bus.IR_write, bus.reg_dst, bus.mem_to_reg,
                bus.reg_write, bus.ALU_src_A, bus.ALU_src_B, bus.ALU_op, bus.PC_src,
                bus.PC_en, bus.instr_done, bus.illegal_op};
  function automatic logic legal(logic [5:0] opc);
    return opc inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction
  function automatic logic [19:0] exp_vec(logic [3:0] st, logic mr, logic z, logic [5:0] opc);
    logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, en = 0, dn = 0, il = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (st)
      0: begin sb = 1; irw = mr; en = mr; end
      1: begin sb = 3; il = !legal(opc); end
      2: begin sa = 1; sb = 2; end
      3: iord = 1;
      4: begin m2r = 1; rw = 1; dn = 1; end
      5: begin iord = 1; mw = 1; dn = mr; end
      6: begin sa = 1; op = 2; end
      7: begin rd = 1; rw = 1; dn = 1; end
      8: begin sa = 1; op = 1; ps = 1; en = z; dn = 1; end
      9: begin sa = 1; sb = 2; end
      10: begin rw = 1; dn = 1; end
      11: begin ps = 2; en = 1; dn = 1; end
      default: ;
    endcase
    return {st, iord, mw, irw, rd, m2r, rw, sa, sb, op, ps, en, dn, il};
  endfunction
  task automatic check(string name, logic [19:0] a, logic [19:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, a, e);
    end
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      check("cycle", act, q.pop_front());
      done_cnt += int'(bus.instr_done);
      ill_cnt += int'(bus.illegal_op);
    end
  task automatic cyc(logic [3:0] st, logic mr, logic [5:0] opc, logic z);
    bus.mem_ready = mr;
    bus.opcode = opc;
    bus.zero = z;
    q.push_back(exp_vec(st, mr, z, opc));
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic [5:0] opc, logic z, int fs, int ms);
    for (int i = 0; i < fs; i++) cyc(0, 1'b0, 6'($urandom), z);
    cyc(0, 1'b1, 6'($urandom), z);
    cyc(1, 1'($urandom), opc, z);
    case (opc)
      OP_LW: begin
        cyc(2, 1'($urandom), opc, z);
        for (int i = 0; i < ms; i++) cyc(3, 1'b0, opc, z);
        cyc(3, 1'b1, opc, z);
        cyc(4, 1'($urandom), opc, z);
      end
      OP_SW: begin
        cyc(2, 1'($urandom), opc, z);
        for (int i = 0; i < ms; i++) cyc(5, 1'b0, opc, z);
        cyc(5, 1'b1, opc, z);
      end
      OP_RTYPE: begin cyc(6, 1'($urandom), opc, z); cyc(7, 1'($urandom), opc, z); end
      OP_ADDI: begin cyc(9, 1'($urandom), opc, z); cyc(10, 1'($urandom), opc, z); end
      OP_BEQ: cyc(8, 1'($urandom), opc, z);
      OP_J: cyc(11, 1'($urandom), opc, z);
      default: ;
    endcase
    if (legal(opc)) legal_n++;
    else illegal_n++;
  endtask
  initial begin
    logic [5:0] ops[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] opc;
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = 6'd0;
    bus.zero = 1'b0;
    #3;
    check("reset_ready", act, exp_vec(0, 1'b1, 1'b0, 6'd0));
    bus.mem_ready = 1'b0;
    #1;
    check("reset_stall", act, exp_vec(0, 1'b0, 1'b0, 6'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(OP_RTYPE, 1'b0, 0, 0);
    issue(OP_LW, 1'b0, 0, 2);
    issue(OP_BEQ, 1'b1, 0, 0);
    issue(OP_BEQ, 1'b0, 0, 0);
    issue(OP_SW, 1'b0, 0, 0);
    issue(OP_J, 1'b0, 0, 0);
    issue(6'b111111, 1'b0, 0, 0);
    issue(OP_ADDI, 1'b1, 2, 0);
    issue(OP_SW, 1'b1, 1, 3);
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 6) == 0)
        do opc = 6'($urandom); while (legal(opc));
      else opc = ops[$urandom_range(0, 5)];
      issue(opc, 1'($urandom), $urandom_range(0, 1) ? 0 : $urandom_range(1, 3),
            $urandom_range(0, 1) ? 0 : $urandom_range(1, 3));
    end
    check("queue_drained", 20'(q.size()), 20'd0);
    check("instr_done_count", 20'(done_cnt), 20'(legal_n));
    check("illegal_count", 20'(ill_cnt), 20'(illegal_n));
    cyc(0, 1'b1, 6'd0, 1'b0);
    cyc(1, 1'b1, OP_SW, 1'b0);
    cyc(2, 1'b0, OP_SW, 1'b0);
    bus.mem_ready = 1'b0;
    q.push_back(exp_vec(5, 1'b0, 1'b0, OP_SW));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop_reset", act, exp_vec(0, 1'b0, 1'b0, OP_SW));
    bus.mem_ready = 1'b1;
    #1;
    check("midop_reset_ready", act, exp_vec(0, 1'b1, 1'b0, OP_SW));
    @(posedge clk);
    #1;
    check("reset_hold", act, exp_vec(0, 1'b1, 1'b0, OP_SW));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
